// File: rtl/ctrl_seq_unit.sv
// ----------------------------------------------------------------------------
// ctrl_seq_unit
//   Registered decode/control unit between IF/ID and the EXE stage register.
//   Decodes the opcode into the EXE/MEM/WB control bundle, holds it behind a
//   valid/ready handshake, and stalls intake for memory wait states after
//   LD/ST and for bubble cycles after branches. Unknown opcodes produce an
//   all-zero bundle with illegal set.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   flush      in   1      synchronous pipeline flush (drops bundle, back to RUN)
//   in_valid   in   1      opcode valid
//   opcode     in   OPC_W  instruction opcode
//   in_ready   out  1      opcode accepted when in_valid && in_ready
//   out_valid  out  1      control bundle valid
//   out_ready  in   1      downstream consumes bundle
//   exe_cmd    out  CMD_W  ALU command (4-bit command zero-extended)
//   mem_r_en   out  1      memory read enable
//   mem_w_en   out  1      memory write enable
//   wb_en      out  1      register writeback enable
//   is_imm     out  1      second operand is immediate
//   br_type    out  2      00 none, 01 BEZ, 10 BNE, 11 JMP
//   illegal    out  1      opcode not in decode table
//   busy       out  1      sequencer is in a wait or branch-shadow state
// ----------------------------------------------------------------------------
module ctrl_seq_unit #(
    parameter int OPC_W        = 6,
    parameter int CMD_W        = 4,
    parameter int MEM_WAIT_CYC = 2,
    parameter int BR_BUBBLES   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [OPC_W-1:0] opcode,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             wb_en,
    output logic             is_imm,
    output logic [1:0]       br_type,
    output logic             illegal,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_BR_SHADOW = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] cmd;
        logic       mem_r;
        logic       mem_w;
        logic       wb;
        logic       imm;
        logic [1:0] br;
        logic       ill;
    } ctrl_t;

    localparam logic [3:0] MEM_CNT = 4'(MEM_WAIT_CYC);
    localparam logic [3:0] BR_CNT  = 4'(BR_BUBBLES);
    localparam bit         MEM_EN  = (MEM_WAIT_CYC > 0);
    localparam bit         BR_EN   = (BR_BUBBLES > 0);

    // Full-width compare: any set bit above the table range falls to default.
    function automatic ctrl_t decode(input logic [OPC_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OPC_W'(0):  ;
            OPC_W'(1):  begin c.cmd = 4'b0000; c.wb = 1'b1; end
            OPC_W'(3):  begin c.cmd = 4'b0010; c.wb = 1'b1; end
            OPC_W'(5):  begin c.cmd = 4'b0100; c.wb = 1'b1; end
            OPC_W'(6):  begin c.cmd = 4'b0101; c.wb = 1'b1; end
            OPC_W'(7):  begin c.cmd = 4'b0110; c.wb = 1'b1; end
            OPC_W'(8):  begin c.cmd = 4'b0111; c.wb = 1'b1; end
            OPC_W'(9),
            OPC_W'(10): begin c.cmd = 4'b1000; c.wb = 1'b1; end
            OPC_W'(11): begin c.cmd = 4'b1001; c.wb = 1'b1; end
            OPC_W'(12): begin c.cmd = 4'b1010; c.wb = 1'b1; end
            OPC_W'(32): begin c.cmd = 4'b0000; c.wb = 1'b1; c.imm = 1'b1; end
            OPC_W'(33): begin c.cmd = 4'b0010; c.wb = 1'b1; c.imm = 1'b1; end
            OPC_W'(36): begin c.mem_r = 1'b1; c.wb = 1'b1; c.imm = 1'b1; end
            OPC_W'(37): begin c.mem_w = 1'b1; c.imm = 1'b1; end
            OPC_W'(40): c.br = 2'b01;
            OPC_W'(41): c.br = 2'b10;
            OPC_W'(42): c.br = 2'b11;
            default:    c.ill = 1'b1;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      dec_p0;
    ctrl_t      ctrl_p1;
    logic       vld_p1;
    logic       accept;

    assign dec_p0 = decode(opcode);
    assign accept = in_valid && in_ready;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state; the wait counter runs regardless of out_ready
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if ((dec_p0.mem_r || dec_p0.mem_w) && MEM_EN) begin
                            state_d = ST_MEM_WAIT;
                            cnt_d   = MEM_CNT;
                        end else if ((dec_p0.br != 2'b00) && BR_EN) begin
                            state_d = ST_BR_SHADOW;
                            cnt_d   = BR_CNT;
                        end
                    end
                end
                ST_MEM_WAIT, ST_BR_SHADOW: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q != ST_RUN);
        in_ready = (state_q == ST_RUN) && !flush && (!vld_p1 || out_ready);
    end

    // Stage p0 -> p1: decoded bundle register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            ctrl_p1 <= dec_p0;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign exe_cmd   = CMD_W'(ctrl_p1.cmd);
    assign mem_r_en  = ctrl_p1.mem_r;
    assign mem_w_en  = ctrl_p1.mem_w;
    assign wb_en     = ctrl_p1.wb;
    assign is_imm    = ctrl_p1.imm;
    assign br_type   = ctrl_p1.br;
    assign illegal   = ctrl_p1.ill;

endmodule
